// File: rtl/seq_cu_pkg.sv
// Shared types for the sequencing control unit: FSM state encodings,
// instruction classes, the packed datapath-control bundle and the IR classifier.
package seq_cu_pkg;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    IC_ALU_I  = 3'd0,
    IC_BRANCH = 3'd1,
    IC_ALU_M  = 3'd2,
    IC_GOTO   = 3'd3,
    IC_NOP    = 3'd4,
    IC_HALT   = 3'd5
  } iclass_t;

  localparam logic [1:0] STAGE_LOAD    = 2'b00;
  localparam logic [1:0] STAGE_FETCH   = 2'b01;
  localparam logic [1:0] STAGE_DECODE  = 2'b10;
  localparam logic [1:0] STAGE_EXECUTE = 2'b11;

  // Top three class bits that mark an instruction needing a data-memory read in DECODE
  localparam logic [2:0] MEM_CLASS = 3'b001;

  typedef struct packed {
    logic pc_e;
    logic acc_e;
    logic sr_e;
    logic ir_e;
    logic dr_e;
    logic pmem_e;
    logic dmem_e;
    logic dmem_we;
    logic alu_e;
    logic mux1_sel;
    logic mux2_sel;
    logic pmem_le;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // First set class bit wins; an all-zero class field splits NOP from HALT on the low field
  function automatic iclass_t classify(input logic [3:0] cls, input logic low_nz);
    iclass_t c;
    if (cls[3])      c = IC_ALU_I;
    else if (cls[2]) c = IC_BRANCH;
    else if (cls[1]) c = IC_ALU_M;
    else if (cls[0]) c = IC_GOTO;
    else if (!low_nz) c = IC_NOP;
    else             c = IC_HALT;
    return c;
  endfunction

endpackage

// File: rtl/seq_cu_decode.sv
// Combinational DECODE/EXECUTE control decode from IR, SR and mem_rdy.
// The FSM decides which of the two bundles actually reaches the datapath.
module seq_cu_decode
  import seq_cu_pkg::*;
#(
  parameter int IR_W       = 12,
  parameter int SR_W       = 4,
  parameter int ALU_MODE_W = 4
) (
  input  logic [IR_W-1:0]       ir,
  input  logic [SR_W-1:0]       sr,
  input  logic                  mem_rdy,
  output ctrl_t                 dec_ctrl,
  output logic                  dec_done,
  output ctrl_t                 exe_ctrl,
  output logic [ALU_MODE_W-1:0] exe_mode,
  output logic                  exe_done,
  output logic                  exe_halt
);

  localparam int M = IR_W - 1;

  iclass_t    cls;
  logic [1:0] br_idx;
  logic       br_take;

  assign cls    = classify(ir[M -: 4], |ir[M-4:0]);
  assign br_idx = ir[M-2:M-3];

  // Branch condition select; indices past the status width read as 0
  always_comb begin
    br_take = 1'b0;
    for (int i = 0; i < SR_W; i++) begin
      if (int'(br_idx) == i) br_take = sr[i];
    end
  end

  // DECODE: memory-class instructions read the data memory and wait for mem_rdy
  always_comb begin
    dec_ctrl = CTRL_NONE;
    dec_done = 1'b1;
    if (ir[M -: 3] == MEM_CLASS) begin
      dec_ctrl.dr_e   = 1'b1;
      dec_ctrl.dmem_e = 1'b1;
      dec_done        = mem_rdy;
    end
  end

  // EXECUTE: per-class enables; the ALU-M store holds until the memory completes
  always_comb begin
    exe_ctrl = CTRL_NONE;
    exe_mode = '0;
    exe_done = 1'b1;
    exe_halt = 1'b0;
    case (cls)
      IC_ALU_I: begin
        exe_ctrl.pc_e     = 1'b1;
        exe_ctrl.acc_e    = 1'b1;
        exe_ctrl.sr_e     = 1'b1;
        exe_ctrl.alu_e    = 1'b1;
        exe_ctrl.mux1_sel = 1'b1;
        exe_mode          = ALU_MODE_W'(ir[M-1:M-3]);
      end
      IC_BRANCH: begin
        exe_ctrl.pc_e     = 1'b1;
        exe_ctrl.mux1_sel = br_take;
      end
      IC_ALU_M: begin
        exe_ctrl.alu_e    = 1'b1;
        exe_ctrl.mux1_sel = 1'b1;
        exe_ctrl.mux2_sel = 1'b1;
        exe_mode          = ALU_MODE_W'(ir[M-4:M-7]);
        if (ir[M-3]) begin
          exe_ctrl.acc_e = 1'b1;
          exe_ctrl.pc_e  = 1'b1;
          exe_ctrl.sr_e  = 1'b1;
        end else begin
          exe_ctrl.dmem_e  = 1'b1;
          exe_ctrl.dmem_we = 1'b1;
          // PC/SR update only once, in the completing cycle
          exe_ctrl.pc_e    = mem_rdy;
          exe_ctrl.sr_e    = mem_rdy;
          exe_done         = mem_rdy;
        end
      end
      IC_GOTO: exe_ctrl.pc_e = 1'b1;
      IC_NOP: begin
        exe_ctrl.pc_e     = 1'b1;
        exe_ctrl.mux1_sel = 1'b1;
      end
      IC_HALT: exe_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_control_unit.sv
// Sequencing control unit for the 8-bit multi-cycle microcontroller.
// Optional performance counters (cyc_cnt, ret_cnt) under macro SEQ_CU_PERF_CNT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// LOAD    | accept program words on load_vld, count load_addr
// FETCH   | load IR from program memory (1 cycle)
// DECODE  | operand read for memory-class instructions, else 1 cycle
// EXECUTE | per-class enables; retire on completion
// HALT    | all enables off until resume (reports stage EXECUTE)
module seq_control_unit
  import seq_cu_pkg::*;
#(
  parameter int IR_W       = 12,
  parameter int PC_W       = 8,
  parameter int PROG_DEPTH = 256,
  parameter int SR_W       = 4,
  parameter int ALU_MODE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_vld,
  input  logic                  mem_rdy,
  input  logic                  resume,
  input  logic [IR_W-1:0]       IR,
  input  logic [SR_W-1:0]       SR,
  output logic [1:0]            stage,
  output logic [PC_W-1:0]       load_addr,
  output logic                  halted,
  output logic                  retire,
  output logic                  pc_e,
  output logic                  acc_e,
  output logic                  sr_e,
  output logic                  ir_e,
  output logic                  dr_e,
  output logic                  pmem_e,
  output logic                  dmem_e,
  output logic                  dmem_we,
  output logic                  alu_e,
  output logic                  mux1_sel,
  output logic                  mux2_sel,
  output logic                  pmem_le,
  output logic [ALU_MODE_W-1:0] ALU_Mode
`ifdef SEQ_CU_PERF_CNT_EN
  ,
  output logic [31:0]           cyc_cnt,
  output logic [31:0]           ret_cnt
`endif
);

  localparam logic [PC_W-1:0] LOAD_LAST = PC_W'(PROG_DEPTH - 1);

  state_t                state;
  logic [PC_W-1:0]       load_cnt;
  ctrl_t                 dec_ctrl;
  ctrl_t                 exe_ctrl;
  logic [ALU_MODE_W-1:0] exe_mode;
  logic                  dec_done;
  logic                  exe_done;
  logic                  exe_halt;
  ctrl_t                 ctrl;
  logic [ALU_MODE_W-1:0] alu_mode_c;
  logic                  retire_c;
  logic [1:0]            stage_c;
  logic                  halted_c;

  seq_cu_decode #(
    .IR_W       (IR_W),
    .SR_W       (SR_W),
    .ALU_MODE_W (ALU_MODE_W)
  ) u_decode (
    .ir       (IR),
    .sr       (SR),
    .mem_rdy  (mem_rdy),
    .dec_ctrl (dec_ctrl),
    .dec_done (dec_done),
    .exe_ctrl (exe_ctrl),
    .exe_mode (exe_mode),
    .exe_done (exe_done),
    .exe_halt (exe_halt)
  );

  // Sequencer state and program-load counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOAD;
      load_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_vld) begin
            if (load_cnt == LOAD_LAST) begin
              load_cnt <= '0;
              state    <= ST_FETCH;
            end else begin
              load_cnt <= load_cnt + PC_W'(1);
            end
          end
        end
        ST_FETCH:   state <= ST_DECODE;
        ST_DECODE:  if (dec_done) state <= ST_EXECUTE;
        ST_EXECUTE: begin
          if (exe_halt)      state <= ST_HALT;
          else if (exe_done) state <= ST_FETCH;
        end
        ST_HALT:    if (resume) state <= ST_FETCH;
        default:    state <= ST_LOAD;
      endcase
    end
  end

  // Output select by state; rst forces everything to 0 so no write completes under reset
  always_comb begin
    ctrl       = CTRL_NONE;
    alu_mode_c = '0;
    retire_c   = 1'b0;
    stage_c    = STAGE_LOAD;
    halted_c   = 1'b0;
    if (!rst) begin
      case (state)
        ST_LOAD: begin
          ctrl.pmem_le = load_vld;
          ctrl.pmem_e  = load_vld;
        end
        ST_FETCH: begin
          stage_c     = STAGE_FETCH;
          ctrl.ir_e   = 1'b1;
          ctrl.pmem_e = 1'b1;
        end
        ST_DECODE: begin
          stage_c = STAGE_DECODE;
          ctrl    = dec_ctrl;
        end
        ST_EXECUTE: begin
          stage_c    = STAGE_EXECUTE;
          ctrl       = exe_ctrl;
          alu_mode_c = exe_mode;
          retire_c   = exe_done;
        end
        ST_HALT: begin
          stage_c       = STAGE_EXECUTE;
          halted_c      = 1'b1;
          ctrl.pc_e     = resume;
          ctrl.mux1_sel = resume;
        end
        default: ;
      endcase
    end
  end

  assign stage     = stage_c;
  assign halted    = halted_c;
  assign retire    = retire_c;
  assign load_addr = rst ? '0 : load_cnt;
  assign ALU_Mode  = alu_mode_c;
  assign pc_e      = ctrl.pc_e;
  assign acc_e     = ctrl.acc_e;
  assign sr_e      = ctrl.sr_e;
  assign ir_e      = ctrl.ir_e;
  assign dr_e      = ctrl.dr_e;
  assign pmem_e    = ctrl.pmem_e;
  assign dmem_e    = ctrl.dmem_e;
  assign dmem_we   = ctrl.dmem_we;
  assign alu_e     = ctrl.alu_e;
  assign mux1_sel  = ctrl.mux1_sel;
  assign mux2_sel  = ctrl.mux2_sel;
  assign pmem_le   = ctrl.pmem_le;

`ifdef SEQ_CU_PERF_CNT_EN
  // Active-cycle and retired-instruction counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (state != ST_LOAD && state != ST_HALT) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire_c) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed testbench for seq_control_unit with PROG_DEPTH=4.
// obs packs {stage, halted, retire, 12 control enables} for compact comparisons.
module tb_seq_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_vld = 1'b0;
  logic        mem_rdy = 1'b0;
  logic        resume = 1'b0;
  logic [11:0] ir = 12'h000;
  logic [3:0]  sr = 4'h0;

  logic [1:0]  stage;
  logic [7:0]  load_addr;
  logic        halted, retire;
  logic        pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, dmem_e, dmem_we;
  logic        alu_e, mux1_sel, mux2_sel, pmem_le;
  logic [3:0]  alu_mode;
`ifdef SEQ_CU_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  localparam logic [11:0] E_PC   = 12'h800;
  localparam logic [11:0] E_ACC  = 12'h400;
  localparam logic [11:0] E_SR   = 12'h200;
  localparam logic [11:0] E_IR   = 12'h100;
  localparam logic [11:0] E_DR   = 12'h080;
  localparam logic [11:0] E_PMEM = 12'h040;
  localparam logic [11:0] E_DMEM = 12'h020;
  localparam logic [11:0] E_WE   = 12'h010;
  localparam logic [11:0] E_ALU  = 12'h008;
  localparam logic [11:0] E_M1   = 12'h004;
  localparam logic [11:0] E_M2   = 12'h002;
  localparam logic [11:0] E_LE   = 12'h001;

  int checks = 0;
  int errors = 0;

  wire [11:0] ctl = {pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, dmem_e, dmem_we,
                     alu_e, mux1_sel, mux2_sel, pmem_le};
  wire [15:0] obs = {stage, halted, retire, ctl};

  seq_control_unit #(
    .IR_W(12), .PC_W(8), .PROG_DEPTH(4), .SR_W(4), .ALU_MODE_W(4)
  ) dut (
    .clk(clk), .rst(rst), .load_vld(load_vld), .mem_rdy(mem_rdy), .resume(resume),
    .IR(ir), .SR(sr), .stage(stage), .load_addr(load_addr), .halted(halted),
    .retire(retire), .pc_e(pc_e), .acc_e(acc_e), .sr_e(sr_e), .ir_e(ir_e),
    .dr_e(dr_e), .pmem_e(pmem_e), .dmem_e(dmem_e), .dmem_we(dmem_we),
    .alu_e(alu_e), .mux1_sel(mux1_sel), .mux2_sel(mux2_sel), .pmem_le(pmem_le),
    .ALU_Mode(alu_mode)
`ifdef SEQ_CU_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    rst = 1'b1; load_vld = 1'b1; mem_rdy = 1'b1; resume = 1'b1; ir = 12'h8A5;
    step(); step();
    @(negedge clk);
    exp = 16'h0000;
    checks++;
    if (obs !== exp || load_addr !== 8'd0 || alu_mode !== 4'd0) begin
      errors++;
      $display("FAIL reset: got obs=%h addr=%0d mode=%0d want obs=%h addr=0 mode=0",
               obs, load_addr, alu_mode, exp);
    end
    load_vld = 1'b0; mem_rdy = 1'b0; resume = 1'b0;
    step();
  endtask

  task automatic test_load();
    logic       v[5];
    logic [7:0] a[5];
    logic [15:0] exp;
    v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    a = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_vld = v[i];
      @(negedge clk);
      exp = {2'b00, 1'b0, 1'b0, (v[i] ? (E_PMEM | E_LE) : 12'h000)};
      checks++;
      if (obs !== exp || load_addr !== a[i]) begin
        errors++;
        $display("FAIL load[%0d]: got obs=%h addr=%0d want obs=%h addr=%0d",
                 i, obs, load_addr, exp, a[i]);
      end
      step();
    end
    load_vld = 1'b0;
    @(negedge clk);
    exp = {2'b01, 1'b0, 1'b0, E_IR | E_PMEM};
    checks++;
    if (obs !== exp || load_addr !== 8'd0) begin
      errors++;
      $display("FAIL load_to_fetch: got obs=%h addr=%0d want obs=%h addr=0",
               obs, load_addr, exp);
    end
  endtask

  typedef struct {
    logic [11:0] ir;
    logic        rdy;
    logic [11:0] dec;
    logic [11:0] exe;
    logic [3:0]  mode;
  } vec_t;

  task automatic test_exec_classes();
    vec_t t[5];
    logic [15:0] exp;
    t[0] = '{12'h8A5, 1'b0, 12'h000, E_PC | E_ACC | E_SR | E_ALU | E_M1, 4'd0};
    t[1] = '{12'hF00, 1'b0, 12'h000, E_PC | E_ACC | E_SR | E_ALU | E_M1, 4'd7};
    t[2] = '{12'h37C, 1'b1, E_DR | E_DMEM, E_PC | E_ACC | E_SR | E_ALU | E_M1 | E_M2, 4'd7};
    t[3] = '{12'h1FF, 1'b0, 12'h000, E_PC, 4'd0};
    t[4] = '{12'h000, 1'b0, 12'h000, E_PC | E_M1, 4'd0};
    for (int i = 0; i < 5; i++) begin
      ir = t[i].ir; mem_rdy = t[i].rdy;
      step();
      @(negedge clk);
      exp = {2'b10, 1'b0, 1'b0, t[i].dec};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL class_decode[%0d]: got obs=%h want obs=%h", i, obs, exp);
      end
      step();
      mem_rdy = 1'b0;
      @(negedge clk);
      exp = {2'b11, 1'b0, 1'b1, t[i].exe};
      checks++;
      if (obs !== exp || alu_mode !== t[i].mode) begin
        errors++;
        $display("FAIL class_exec[%0d]: got obs=%h mode=%0d want obs=%h mode=%0d",
                 i, obs, alu_mode, exp, t[i].mode);
      end
      step();
      @(negedge clk);
      exp = {2'b01, 1'b0, 1'b0, E_IR | E_PMEM};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL class_fetch[%0d]: got obs=%h want obs=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_branch();
    logic [11:0] bir[4];
    logic [3:0]  bsr[4];
    logic        bm1[4];
    logic [15:0] exp;
    bir = '{12'h6A5, 12'h6A5, 12'h7A5, 12'h7A5};
    bsr = '{4'b0100, 4'b0000, 4'b1000, 4'b0111};
    bm1 = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      ir = bir[i]; sr = bsr[i]; mem_rdy = 1'b0;
      step(); step();
      @(negedge clk);
      exp = {2'b11, 1'b0, 1'b1, (E_PC | (bm1[i] ? E_M1 : 12'h000))};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL branch[%0d]: got obs=%h want obs=%h", i, obs, exp);
      end
      step();
      @(negedge clk);
      checks++;
      if (stage !== 2'b01) begin
        errors++;
        $display("FAIL branch_fetch[%0d]: got stage=%b want stage=01", i, stage);
      end
    end
    sr = 4'h0;
  endtask

  task automatic test_alu_m_store();
    logic [15:0] exp;
    int rets;
    ir = 12'h230; mem_rdy = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      mem_rdy = (c == 2);
      @(negedge clk);
      exp = {2'b10, 1'b0, 1'b0, E_DR | E_DMEM};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL store_decode[%0d]: got obs=%h want obs=%h", c, obs, exp);
      end
      step();
    end
    rets = 0;
    for (int c = 0; c < 4; c++) begin
      mem_rdy = (c == 3);
      @(negedge clk);
      rets += int'(retire);
      exp = {2'b11, 1'b0, (c == 3), (E_ALU | E_M1 | E_M2 | E_DMEM | E_WE |
                                     ((c == 3) ? (E_PC | E_SR) : 12'h000))};
      checks++;
      if (obs !== exp || alu_mode !== 4'd3) begin
        errors++;
        $display("FAIL store_exec[%0d]: got obs=%h mode=%0d want obs=%h mode=3",
                 c, obs, alu_mode, exp);
      end
      step();
    end
    checks++;
    if (rets !== 1) begin
      errors++;
      $display("FAIL store_retire_count: got %0d want 1", rets);
    end
    mem_rdy = 1'b0;
    @(negedge clk);
    exp = {2'b01, 1'b0, 1'b0, E_IR | E_PMEM};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL store_fetch: got obs=%h want obs=%h", obs, exp);
    end
  endtask

  task automatic test_halt_resume();
    logic [15:0] exp;
    ir = 12'h001; mem_rdy = 1'b0;
    step();
    @(negedge clk);
    exp = {2'b10, 1'b0, 1'b0, 12'h000};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL halt_decode: got obs=%h want obs=%h", obs, exp);
    end
    step();
    @(negedge clk);
    exp = {2'b11, 1'b0, 1'b1, 12'h000};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL halt_exec: got obs=%h want obs=%h", obs, exp);
    end
    step();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp = {2'b11, 1'b1, 1'b0, 12'h000};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got obs=%h want obs=%h", c, obs, exp);
      end
      step();
    end
    resume = 1'b1;
    @(negedge clk);
    exp = {2'b11, 1'b1, 1'b0, E_PC | E_M1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL halt_resume: got obs=%h want obs=%h", obs, exp);
    end
    step();
    resume = 1'b0;
    @(negedge clk);
    exp = {2'b01, 1'b0, 1'b0, E_IR | E_PMEM};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL halt_exit_fetch: got obs=%h want obs=%h", obs, exp);
    end
    ir = 12'h000; resume = 1'b1;
    step();
    resume = 1'b0;
    @(negedge clk);
    exp = {2'b10, 1'b0, 1'b0, 12'h000};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL resume_ignored: got obs=%h want obs=%h", obs, exp);
    end
    step();
    @(negedge clk);
    exp = {2'b11, 1'b0, 1'b1, E_PC | E_M1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL resume_nop_exec: got obs=%h want obs=%h", obs, exp);
    end
    step();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stall();
    logic [15:0] exp;
    ir = 12'h230; mem_rdy = 1'b0;
    step();
    @(negedge clk);
    exp = {2'b10, 1'b0, 1'b0, E_DR | E_DMEM};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rst_stall_decode: got obs=%h want obs=%h", obs, exp);
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 16'h0000 || load_addr !== 8'd0) begin
      errors++;
      $display("FAIL rst_asserted: got obs=%h addr=%0d want obs=0000 addr=0", obs, load_addr);
    end
    step();
    rst = 1'b0; load_vld = 1'b1;
    @(negedge clk);
    exp = {2'b00, 1'b0, 1'b0, E_PMEM | E_LE};
    checks++;
    if (obs !== exp || load_addr !== 8'd0) begin
      errors++;
      $display("FAIL rst_to_load: got obs=%h addr=%0d want obs=%h addr=0", obs, load_addr, exp);
    end
    step();
    load_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 16'h0000 || load_addr !== 8'd1) begin
      errors++;
      $display("FAIL rst_reload: got obs=%h addr=%0d want obs=0000 addr=1", obs, load_addr);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_exec_classes();
    test_branch();
    test_alu_m_store();
    test_halt_resume();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_control_unit.md
Name: seq_control_unit

Overview:
- Parametrised successor to the stage-driven combinational control unit of the 8-bit multi-cycle microcontroller.
- Owns the LOAD/FETCH/DECODE/EXECUTE sequencer internally, so the top level no longer needs a separate stage counter.
- Adds: handshaked program load, data-memory wait-state stalling, a HALT instruction with resume, and a retire pulse.
- Decodes the same instruction classes, and drives the same datapath enables, muxes and ALU mode.

Parameters:
- IR_W, 12, instruction width; opcode class bits are IR[IR_W-1:IR_W-4], remaining fields are positioned relative to them.
- PC_W, 8, program-memory address width; the load counter spans 0..PROG_DEPTH-1.
- PROG_DEPTH, 256, number of words loaded in LOAD; must be ≤ 2**PC_W.
- SR_W, 4, status register width; the branch condition index is clog2(SR_W) bits.
- ALU_MODE_W, 4, ALU mode width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- load_vld  in  1  external loader presents a program word this cycle
- mem_rdy  in  1  data memory completes the access this cycle
- resume  in  1  single-cycle pulse that leaves HALT
- IR  in  IR_W  current instruction register
- SR  in  SR_W  status flags
- stage  out  2  current state: LOAD=00, FETCH=01, DECODE=10, EXECUTE=11
- load_addr  out  PC_W  program-memory write address during LOAD
- halted  out  1  core is in HALT
- retire  out  1  one-cycle pulse when an instruction completes EXECUTE
- pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, dmem_e, dmem_we, alu_e, mux1_sel, mux2_sel, pmem_le  out  1 each  datapath controls
- ALU_Mode  out  ALU_MODE_W  ALU operation select

Behaviour:
- Reset:
  - While rst=1, all outputs are 0, stage=LOAD and load_addr=0.
  - The first cycle after rst falls is LOAD with a count of 0.
  - rst mid-operation aborts at once; no partial dmem write is ever completed.
- Internal state: LOAD, FETCH, DECODE, EXECUTE, HALT. HALT drives stage=EXECUTE and halted=1.
- LOAD:
  - pmem_le=pmem_e=load_vld.
  - load_addr increments when load_vld=1.
  - When load_vld=1 and load_addr=PROG_DEPTH-1, go to FETCH next cycle; load_addr wraps to 0.
- FETCH: ir_e=pmem_e=1; next state DECODE. Always 1 cycle.
- DECODE:
  - If IR class bits [IR_W-1:IR_W-3]=001: dr_e=dmem_e=1. Stay in DECODE while mem_rdy=0; go to EXECUTE on the first mem_rdy=1.
  - Otherwise, go to EXECUTE after 1 cycle; mem_rdy is ignored.
- EXECUTE, first match wins (m = IR_W-1):
  - IR[m]=1, ALU-I:
    - pc_e=acc_e=sr_e=alu_e=mux1_sel=1.
    - ALU_Mode is IR[m-1:m-3], zero-extended to ALU_MODE_W.
  - IR[m-1]=1, branch: pc_e=1; mux1_sel=SR[IR[m-2:m-3]]. An index ≥ SR_W gives 0.
  - IR[m-2]=1, ALU-M:
    - alu_e=sr_e=mux1_sel=mux2_sel=1; ALU_Mode=IR[m-4:m-7].
    - If IR[m-3]=1: acc_e=pc_e=1, single cycle.
    - If IR[m-3]=0: dmem_e=dmem_we=1, held while mem_rdy=0. pc_e and sr_e are asserted only in the cycle where mem_rdy=1, so there is exactly one PC and SR update per instruction.
  - IR[m-3]=1, GOTO: pc_e=1.
  - IR=0, NOP: pc_e=mux1_sel=1.
  - IR[m:m-3]=0 with a nonzero low field: HALT. No enables are asserted; go to HALT.
- Exit from EXECUTE: on completion go to FETCH and pulse retire. HALT retires on its entry cycle.
- HALT:
  - All enables are 0.
  - resume=1 sets pc_e=mux1_sel=1 (PC+1) for that cycle, then the next state is FETCH.
  - resume while not in HALT is ignored.
- Simultaneous rst and resume: rst wins.

Optional Feature:
- Macro SEQ_CU_PERF_CNT_EN.
- When defined, add outputs cyc_cnt[31:0] and ret_cnt[31:0]:
  - cyc_cnt increments on every non-LOAD, non-HALT cycle.
  - ret_cnt increments on retire.
  - Both clear on rst and wrap at 2**32.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package seq_cu_pkg holds:
  - State encodings: LOAD, FETCH, DECODE, EXECUTE, HALT.
  - Instruction-class constants: ALU_I, BRANCH, ALU_M, GOTO, NOP, HALT.
  - A function that classifies IR into those classes.
- One natural sub-module: seq_cu_decode, the purely combinational EXECUTE and DECODE control decode from IR, SR and mem_rdy. The FSM and counters stay in the top module.

Test Plan:
- Load handshake: PROG_DEPTH=4, load_vld toggling 1,0,1,1,1 → load_addr goes 0,1,1,2,3; FETCH is entered the cycle after the 4th accepted word; pmem_le never asserts while load_vld=0.
- ALU-I: IR=12'h8A5 → EXECUTE shows pc_e=acc_e=sr_e=alu_e=mux1_sel=1, ALU_Mode=4'b0000; one retire pulse; FETCH follows.
- Branch condition:
  - IR=12'h6xx with SR=4'b0100 → mux1_sel=1.
  - The same IR with SR=0 → mux1_sel=0.
- ALU-M store with 3 wait cycles: IR=12'h230, mem_rdy low for 3 cycles → dmem_we held for 4 cycles; pc_e and sr_e high only in the 4th; exactly one retire.
- HALT and resume: IR=12'h001 → halted=1 with all enables 0 for 10 cycles; a resume pulse gives pc_e=mux1_sel=1 for one cycle, then FETCH.
- Reset mid-stall: rst asserted during DECODE with mem_rdy=0 → next cycle all outputs 0, stage=LOAD, load_addr=0.
